// File: rtl/alu_flag_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_flag_ctrl_pkg
// Shared definitions for the condition-code register (CCR) controller:
//   - flag bit positions inside the CCR
//   - jump condition encodings as seen on jmp_cond
//   - default CCR width
// -----------------------------------------------------------------------------
package alu_flag_ctrl_pkg;

    // Default CCR width: Z, N, C plus two reserved pass-through bits.
    localparam int FLAG_W_DEFAULT = 5;

    // Flag bit positions inside the CCR.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // Jump condition encodings.
    typedef enum logic [1:0] {
        JMP_UNCOND = 2'b00,
        JMP_Z      = 2'b01,
        JMP_N      = 2'b10,
        JMP_C      = 2'b11
    } jmp_cond_e;

endpackage : alu_flag_ctrl_pkg

// File: rtl/alu_flag_ctrl_flag_lifo.sv
// -----------------------------------------------------------------------------
// alu_flag_ctrl_flag_lifo
// DEPTH-entry LIFO holding saved CCR values across interrupt entry / RTI.
// The pointer saturates at 0 and DEPTH; it never wraps.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears pointer and entries)
//   push      in   store din on top of the stack (dropped when full)
//   pop       in   remove the top entry (ignored when empty)
//   din       in   FLAG_W value to push
//   dout      out  current top entry (entry sp-1); zero when empty
//   full      out  stack holds DEPTH entries
//   empty     out  stack holds no entries
//   overflow  out  push attempted while full (single-cycle pulse)
//   underflow out  pop attempted while empty (single-cycle pulse)
// -----------------------------------------------------------------------------
module alu_flag_ctrl_flag_lifo
    import alu_flag_ctrl_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [FLAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;

    // Flags decode straight from the registered pointer, so they never glitch.
    assign full      = (sp == PTR_W'(DEPTH));
    assign empty     = (sp == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;

    // Top-of-stack read. The loop selects entry sp-1 without ever forming an
    // out-of-range index when sp is 0.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i + 1) == sp) begin
                dout = mem[i];
            end
        end
    end

    // NOTE: the storage array is reset along with the pointer because the
    // saved entries must read back as zero after reset; this keeps it in
    // flops rather than a RAM macro, which is fine at this depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (PTR_W'(i) == sp) begin
                    mem[i] <= din;
                end
            end
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule : alu_flag_ctrl_flag_lifo

// File: rtl/alu_flag_ctrl.sv
// -----------------------------------------------------------------------------
// alu_flag_ctrl
// Owns the condition-code register that feeds the ALU flag input. Captures
// ALU flag writes, resolves conditional jumps against forwarded flags
// (clearing the tested flag on a taken conditional jump), and saves/restores
// the CCR through a small LIFO on interrupt entry and RTI.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   stall        in   freezes all state; forces jmp_taken low
//   flag_we      in   EX-stage instruction writes flags this cycle
//   alu_flags    in   ALU flag output (FLAG_W)
//   ccr          out  registered CCR (FLAG_W), drives the ALU flag input
//   jmp_valid    in   a jump is being resolved this cycle
//   jmp_cond     in   00 uncond, 01 JZ, 10 JN, 11 JC
//   jmp_taken    out  combinational jump decision
//   int_save     in   push CCR (interrupt entry)
//   rti_restore  in   pop into CCR (RTI)
//   stack_empty  out  LIFO holds no entries
//   stack_full   out  LIFO holds DEPTH entries
//   err          out  sticky overflow / underflow / save+restore collision
// -----------------------------------------------------------------------------
module alu_flag_ctrl
    import alu_flag_ctrl_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flag_we,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] ccr,
    input  logic              jmp_valid,
    input  logic [1:0]        jmp_cond,
    output logic              jmp_taken,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              err
);

    logic [FLAG_W-1:0] eff;
    logic [FLAG_W-1:0] clr_mask;
    logic [FLAG_W-1:0] normal_next;
    logic [FLAG_W-1:0] ccr_next;
    logic [FLAG_W-1:0] lifo_top;
    logic              cond_hit;
    logic              collide;
    logic              do_push;
    logic              do_pop;
    logic              lifo_ovf;
    logic              lifo_unf;
    logic              err_set;
    jmp_cond_e         cond;

    assign cond = jmp_cond_e'(jmp_cond);

    // Flags forwarded from the instruction in EX, so a jump in the same cycle
    // sees the value the write is about to commit.
    assign eff = flag_we ? alu_flags : ccr;

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        cond_hit = 1'b0;
        clr_mask = '0;
        case (cond)
            JMP_UNCOND: cond_hit = 1'b1;
            JMP_Z: begin
                cond_hit         = eff[FLAG_Z];
                clr_mask[FLAG_Z] = 1'b1;
            end
            JMP_N: begin
                cond_hit         = eff[FLAG_N];
                clr_mask[FLAG_N] = 1'b1;
            end
            JMP_C: begin
                cond_hit         = eff[FLAG_C];
                clr_mask[FLAG_C] = 1'b1;
            end
            default: ;
        endcase
    end

    assign jmp_taken = jmp_valid & ~stall & cond_hit;

    // Unconditional jumps leave clr_mask at zero, and reserved bits are never
    // in the mask, so they always pass through.
    assign normal_next = jmp_taken ? (eff & ~clr_mask) : eff;

    // A simultaneous save and restore is rejected outright: neither the stack
    // nor the restore path moves, only the normal flag/jump path applies.
    assign collide = int_save & rti_restore;
    assign do_push = ~stall & int_save & ~rti_restore;
    assign do_pop  = ~stall & rti_restore & ~int_save;

    // A successful restore overrides the flag write and any jump clear.
    assign ccr_next = (do_pop && !stack_empty) ? lifo_top : normal_next;

    assign err_set = ~stall & (collide | lifo_ovf | lifo_unf);

    // Saves capture eff: the post-write value, before any jump clear.
    alu_flag_ctrl_flag_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .din       (eff),
        .dout      (lifo_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .overflow  (lifo_ovf),
        .underflow (lifo_unf)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr <= '0;
            err <= 1'b0;
        end else if (!stall) begin
            ccr <= ccr_next;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule : alu_flag_ctrl

// File: doc/alu_flag_ctrl.md
Name: alu_flag_ctrl

Overview:
Owns the condition-code register (CCR) that feeds the ALU's 5-bit flag input and captures the ALU's flag output.
- Sequences flag writes from the EX stage.
- Evaluates conditional jumps against forwarded flags and clears the tested flag when a jump is taken.
- Saves and restores the CCR on interrupt entry and RTI through a small LIFO.
- Sits beside the EX stage. Its ccr output drives the ALU flag input; the ALU flag output returns as alu_flags.

Parameters:
FLAG_W, 5, CCR width; bit0 zero, bit1 sign, bit2 carry, bits 3-4 reserved and passed through.
DEPTH, 4, number of entries in the saved-flags LIFO; must be >= 1.
PTR_W, 3, stack pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  freezes all state updates; forces jmp_taken=0
flag_we  in  1  EX-stage instruction writes flags this cycle
alu_flags  in  FLAG_W  flag output of the ALU
ccr  out  FLAG_W  registered CCR; drives the ALU flag input
jmp_valid  in  1  a jump is being resolved this cycle
jmp_cond  in  2  00 unconditional, 01 JZ, 10 JN, 11 JC
jmp_taken  out  1  combinational jump decision
int_save  in  1  push CCR (interrupt entry)
rti_restore  in  1  pop into CCR (RTI)
stack_empty  out  1  LIFO holds 0 entries
stack_full  out  1  LIFO holds DEPTH entries
err  out  1  sticky: overflow, underflow, or simultaneous save+restore

Behaviour:
- Reset (rst=1 at a clk edge): ccr=0, sp=0, err=0, all stack entries=0. Consequently stack_empty=1 and stack_full=0. Reset beats every other input, including mid-sequence saves.
- Forwarded flags: eff = flag_we ? alu_flags : ccr. All jump evaluation uses eff.
- jmp_taken = jmp_valid & ~stall & (cond==00 | (cond==01 & eff[0]) | (cond==10 & eff[1]) | (cond==11 & eff[2])). This is combinational, with zero latency.
- CCR next-state when stall=0, in priority order:
  1. rti_restore & int_save: illegal. err<=1; ccr, sp and stack are unchanged. The jump/flag_we path below still applies.
  2. rti_restore alone, stack non-empty: ccr<=stack[sp-1], sp<=sp-1. This overrides flag_we and any jump clear in the same cycle.
  3. rti_restore alone, stack empty: err<=1; ccr follows the normal path (item 5).
  4. int_save alone, stack not full: stack[sp]<=eff (the post-write value, before any jump clear), sp<=sp+1. If full: err<=1, push dropped, sp unchanged. ccr follows the normal path.
  5. Normal path: ccr<=eff, except that a taken conditional jump clears its tested bit (JZ clears bit0, JN bit1, JC bit2). An unconditional jump clears nothing.
- Latency: flag write visible on ccr one cycle after flag_we. Restore visible one cycle after rti_restore.
- Stall=1: ccr, sp, stack and err all hold. Inputs are ignored except rst.
- err is sticky until rst.
- Reserved bits 3-4 pass through writes, saves and restores untouched; jumps never clear them.
- Stack pointer range is 0..DEPTH with no wrap-around. stack_full=(sp==DEPTH); stack_empty=(sp==0). Both are registered-derived and free of glitches.

Decomposition:
- Shared package holds:
  - flag bit index constants: FLAG_Z=0, FLAG_N=1, FLAG_C=2
  - jump condition encodings: JMP_UNCOND, JMP_Z, JMP_N, JMP_C
  - default FLAG_W
- Natural sub-module: flag_lifo. It contains DEPTH x FLAG_W storage with push/pop/full/empty and the overflow/underflow error pulses. The top level does priority, forwarding and the jump logic.

Test Plan:
- Reset then flag_we=1, alu_flags=5'b00001 -> ccr=5'b00001 next cycle; stack_empty=1; err=0.
- ccr=5'b00001, jmp_valid=1, cond=01, flag_we=0 -> jmp_taken=1 same cycle; ccr=5'b00000 next cycle. Repeat with cond=11 -> jmp_taken=0, ccr unchanged.
- Forwarding: ccr=0, flag_we=1, alu_flags=5'b00100, jmp_valid=1, cond=11 -> jmp_taken=1; ccr=5'b00000 next cycle (write applied, then C cleared).
- Save ccr=5'b00110, then flag_we writes 5'b00001, then rti_restore -> ccr=5'b00110; stack_empty=1.
- DEPTH+1 consecutive int_save pulses -> stack_full=1 after DEPTH pulses; err=1 after pulse DEPTH+1; sp stays DEPTH. Then rst -> ccr=0, stack_empty=1, err=0.
- stall=1 with flag_we=1, int_save=1, jmp_valid=1 -> jmp_taken=0; ccr, sp, err unchanged. int_save=1 with rti_restore=1 (stall=0) -> err=1; sp unchanged.
